// File: rtl/alu_pkg.sv
// Shared types and constants for the demux router.
//   SIZE_DEFAULT : default data width of a routed word
//   channel_e    : output channel identifier (Y0 / Y1)
//   slot_state_e : occupancy of a one-entry output slot
package alu_pkg;

   localparam int SIZE_DEFAULT = 4;
   localparam int CNT_W_DEFAULT = 8;

   typedef enum logic {
      CH_Y0 = 1'b0,
      CH_Y1 = 1'b1
   } channel_e;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output buffer for a single router channel, with delivery counter.
//   clk, rst_n  : clock, synchronous active-low reset
//   load        : write load_data into the slot this cycle
//   load_data   : word to store
//   ready       : consumer takes the word when valid
//   data, valid : slot contents and occupancy
//   count       : words delivered, wraps modulo 2^CNT_W
//
// state      | meaning
// SLOT_EMPTY | no word held; data keeps the last delivered value
// SLOT_FULL  | word held and presented on data with valid=1
module demux_out_slot
   import alu_pkg::*;
#(
   parameter int SIZE  = SIZE_DEFAULT,
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [SIZE-1:0]  load_data,
   input  logic             ready,
   output logic [SIZE-1:0]  data,
   output logic             valid,
   output logic [CNT_W-1:0] count
);

   slot_state_e state_q;
   slot_state_e state_d;
   logic        drain;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= SLOT_EMPTY;
         data    <= '0;
         count   <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            data <= load_data;
         end
         if (drain) begin
            count <= count + 1'b1;
         end
      end
   end

   // A load in the same cycle as a drain keeps the slot full with the new word.
   always_comb begin
      state_d = state_q;
      case (state_q)
         SLOT_EMPTY: if (load) state_d = SLOT_FULL;
         SLOT_FULL:  if (drain && !load) state_d = SLOT_EMPTY;
         default:    state_d = SLOT_EMPTY;
      endcase
   end

   always_comb begin
      valid = (state_q == SLOT_FULL);
      drain = valid && ready;
   end

endmodule

// File: rtl/four_bit_demux_router.sv
// Registered 1-to-2 demultiplexer with valid/ready flow control.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_data, in_valid   : input word stream
//   in_ready            : router accepts this cycle (combinational)
//   S                   : destination select when alt_mode=0
//   alt_mode            : 1 = ping-pong between Y0 and Y1, S ignored
//   Y0/Y1, yN_valid     : channel data and occupancy
//   yN_ready            : channel consumer takes the word
//   yN_count            : per-channel delivery counters
module four_bit_demux_router
   import alu_pkg::*;
#(
   parameter int SIZE  = SIZE_DEFAULT,
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [SIZE-1:0]  in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             S,
   input  logic             alt_mode,
   output logic [SIZE-1:0]  Y0,
   output logic [SIZE-1:0]  Y1,
   output logic             y0_valid,
   output logic             y1_valid,
   input  logic             y0_ready,
   input  logic             y1_ready,
   output logic [CNT_W-1:0] y0_count,
   output logic [CNT_W-1:0] y1_count
);

   channel_e dst;
   logic     pp;
   logic     accept;
   logic     load0;
   logic     load1;

   assign dst = alt_mode ? channel_e'(pp) : channel_e'(S);

   // A full slot can still take a word when its consumer drains in the same cycle.
   always_comb begin
      in_ready = 1'b0;
      case (dst)
         CH_Y0:   in_ready = !y0_valid || y0_ready;
         CH_Y1:   in_ready = !y1_valid || y1_ready;
         default: in_ready = 1'b0;
      endcase
   end

   assign accept = in_valid && in_ready;
   assign load0  = accept && (dst == CH_Y0);
   assign load1  = accept && (dst == CH_Y1);

   // pp survives alt_mode changes; only reset clears it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pp <= 1'b0;
      end else if (accept && alt_mode) begin
         pp <= ~pp;
      end
   end

   demux_out_slot #(
      .SIZE  (SIZE),
      .CNT_W (CNT_W)
   ) u_slot_y0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load0),
      .load_data (in_data),
      .ready     (y0_ready),
      .data      (Y0),
      .valid     (y0_valid),
      .count     (y0_count)
   );

   demux_out_slot #(
      .SIZE  (SIZE),
      .CNT_W (CNT_W)
   ) u_slot_y1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load1),
      .load_data (in_data),
      .ready     (y1_ready),
      .data      (Y1),
      .valid     (y1_valid),
      .count     (y1_count)
   );

endmodule

// File: tb/tb_four_bit_demux_router.sv
// Self-checking bench for four_bit_demux_router: directed scenarios plus
// random traffic, all compared against a behavioural slot/counter model.
module tb_four_bit_demux_router;

   localparam int SIZE  = 4;
   localparam int CNT_W = 8;

   logic             clk;
   logic             rst_n;
   logic [SIZE-1:0]  in_data;
   logic             in_valid;
   logic             in_ready;
   logic             S;
   logic             alt_mode;
   logic [SIZE-1:0]  Y0;
   logic [SIZE-1:0]  Y1;
   logic             y0_valid;
   logic             y1_valid;
   logic             y0_ready;
   logic             y1_ready;
   logic [CNT_W-1:0] y0_count;
   logic [CNT_W-1:0] y1_count;

   int checks;
   int errors;

   // reference model
   bit              full_m [2];
   logic [SIZE-1:0] data_m [2];
   int              cnt_m  [2];
   bit              pp_m;

   four_bit_demux_router #(
      .SIZE  (SIZE),
      .CNT_W (CNT_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .S        (S),
      .alt_mode (alt_mode),
      .Y0       (Y0),
      .Y1       (Y1),
      .y0_valid (y0_valid),
      .y1_valid (y1_valid),
      .y0_ready (y0_ready),
      .y1_ready (y1_ready),
      .y0_count (y0_count),
      .y1_count (y1_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         full_m[i] = 1'b0;
         data_m[i] = '0;
         cnt_m[i]  = 0;
      end
      pp_m = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      S        = 1'b0;
      alt_mode = 1'b0;
      y0_ready = 1'b0;
      y1_ready = 1'b0;
      @(posedge clk);
      #1;
      model_reset();
      rst_n = 1'b1;
      #1;
      check_val("rst_in_ready", in_ready, 1);
   endtask

   // Drive one cycle of inputs, compare DUT against the model before the
   // edge, then advance the model and the DUT across the edge.
   task automatic drive(input logic v, input logic [SIZE-1:0] d, input logic s,
                        input logic alt, input logic r0, input logic r1);
      int dst;
      bit rdy;
      bit acc;
      bit dr [2];
      in_valid = v;
      in_data  = d;
      S        = s;
      alt_mode = alt;
      y0_ready = r0;
      y1_ready = r1;
      #1;
      dst = alt ? int'(pp_m) : int'(s);
      rdy = !full_m[dst] || (dst == 0 ? r0 : r1);
      acc = v && rdy;
      dr[0] = full_m[0] && r0;
      dr[1] = full_m[1] && r1;
      check_val("in_ready", in_ready, rdy);
      check_val("y0_valid", y0_valid, full_m[0]);
      check_val("y1_valid", y1_valid, full_m[1]);
      check_val("Y0", Y0, data_m[0]);
      check_val("Y1", Y1, data_m[1]);
      check_val("y0_count", y0_count, cnt_m[0] % (1 << CNT_W));
      check_val("y1_count", y1_count, cnt_m[1] % (1 << CNT_W));
      for (int i = 0; i < 2; i++) begin
         if (dr[i]) begin
            cnt_m[i]  = cnt_m[i] + 1;
            full_m[i] = 1'b0;
         end
      end
      if (acc) begin
         full_m[dst] = 1'b1;
         data_m[dst] = d;
         if (alt) pp_m = !pp_m;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [SIZE-1:0] w;
      checks = 0;
      errors = 0;
      rst_n  = 1'b1;
      model_reset();
      #2;

      // reset then select mode
      apply_reset();
      check_val("rst_y0_valid", y0_valid, 0);
      check_val("rst_Y1", Y1, 0);
      drive(1, 4'b0011, 0, 0, 1, 1);
      check_val("sel_Y0", Y0, 4'b0011);
      check_val("sel_y0_valid", y0_valid, 1);
      drive(1, 4'b1011, 1, 0, 1, 1);
      check_val("sel_Y1", Y1, 4'b1011);
      check_val("sel_y1_valid", y1_valid, 1);
      drive(0, 4'b0000, 0, 0, 1, 1);
      check_val("sel_cnt0", y0_count, 1);
      check_val("sel_cnt1", y1_count, 1);

      // ping-pong, S random and ignored
      apply_reset();
      for (int v = 0; v < 8; v++) begin
         w = SIZE'(v);
         drive(1, w, 1'($urandom_range(1, 0)), 1, 1, 1);
         if (v % 2 == 0) check_val("pp_Y0", Y0, v);
         else            check_val("pp_Y1", Y1, v);
      end
      drive(0, 4'b0000, 0, 1, 1, 1);
      check_val("pp_cnt0", y0_count, 4);
      check_val("pp_cnt1", y1_count, 4);

      // backpressure on Y0
      apply_reset();
      drive(1, 4'b0101, 0, 0, 0, 1);
      check_val("bp_Y0", Y0, 4'b0101);
      drive(1, 4'b1100, 0, 0, 0, 1);
      check_val("bp_hold_Y0", Y0, 4'b0101);
      check_val("bp_hold_valid", y0_valid, 1);
      drive(1, 4'b1100, 0, 0, 1, 1);
      check_val("bp_next_Y0", Y0, 4'b1100);
      check_val("bp_cnt_a", y0_count, 1);
      drive(0, 4'b0000, 0, 0, 1, 1);
      check_val("bp_cnt_b", y0_count, 2);
      check_val("bp_empty", y0_valid, 0);

      // same-cycle drain and refill on Y1
      apply_reset();
      drive(1, 4'b1001, 1, 0, 1, 0);
      check_val("rf_Y1_first", Y1, 4'b1001);
      drive(1, 4'b1110, 1, 0, 1, 1);
      check_val("rf_valid", y1_valid, 1);
      check_val("rf_Y1", Y1, 4'b1110);
      check_val("rf_cnt1", y1_count, 1);

      // counter wrap on Y0 with Y1 holding a count of one
      apply_reset();
      drive(1, 4'b0110, 1, 0, 1, 1);
      for (int i = 0; i < 256; i++) begin
         drive(1, 4'($urandom_range(15, 0)), 0, 0, 1, 1);
      end
      drive(0, 4'b0000, 0, 0, 1, 1);
      check_val("wrap_cnt0", y0_count, 0);
      check_val("wrap_cnt1", y1_count, 1);

      // reset mid-operation with both slots full and pp=1
      apply_reset();
      drive(1, 4'b0111, 1, 0, 0, 0);
      drive(1, 4'b1101, 0, 1, 0, 0);
      check_val("mid_full0", y0_valid, 1);
      check_val("mid_full1", y1_valid, 1);
      apply_reset();
      check_val("mid_v0", y0_valid, 0);
      check_val("mid_v1", y1_valid, 0);
      check_val("mid_cnt0", y0_count, 0);
      drive(1, 4'b1010, 1, 1, 1, 1);
      check_val("mid_pp_Y0", Y0, 4'b1010);
      check_val("mid_pp_v1", y1_valid, 0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)),
               1'($urandom_range(1, 0)), 1'($urandom_range(3, 0) == 0),
               1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      end
      drive(0, 4'b0000, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
